// File: rtl/formula_pipe_credit_buffer.sv
// Credit-gated issue stage plus result FIFO wrapping a fixed-latency formula pipe.
// Every issued argument set owns a FIFO slot, so results can never overflow.
module formula_pipe_credit_buffer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_vld,
  output logic                       in_rdy,
  output logic                       issue_vld,
  input  logic                       res_vld,
  input  logic [WIDTH-1:0]           res,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] credits,
  output logic                       proto_err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0]    occupied;
  logic [CW-1:0]    count;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    occupied_nxt;
  logic [CW-1:0]    count_nxt;
  logic             pop;
  logic             wr_en;
  logic             err;

  // Handshake decode from registered state; rst forces the idle/credit-full view.
  always_comb begin
    in_rdy       = !rst && (occupied < FULL);
    issue_vld    = in_vld && in_rdy;
    out_vld      = !rst && (count != '0);
    out_data     = mem[rd_ptr];
    credits      = rst ? FULL : FULL - occupied;
    pop          = out_vld && out_rdy;
    wr_en        = res_vld && ((count < FULL) || pop);
    err          = res_vld && (!wr_en || (occupied == '0));
    occupied_nxt = occupied;
    count_nxt    = count;
    if (issue_vld && !pop) begin
      occupied_nxt = occupied + CW'(1);
    end else if (pop && !issue_vld && (occupied != '0)) begin
      occupied_nxt = occupied - CW'(1);
    end
    if (wr_en && !pop) begin
      count_nxt = count + CW'(1);
    end else if (pop && !wr_en) begin
      count_nxt = count - CW'(1);
    end
  end

  // Credit, occupancy, pointer and sticky error state.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupied  <= '0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      proto_err <= 1'b0;
    end else begin
      occupied <= occupied_nxt;
      count    <= count_nxt;
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (err) begin
        proto_err <= 1'b1;
      end
    end
  end

  // Result storage; contents beyond count are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_ptr] <= res;
    end
  end

endmodule
